// File: rtl/regfile_bist_if.sv
// Register-file test-port bundle.
//   master : BIST side, drives write/read controls and samples read data
//   slave  : register-file side
// Signals: t_ctrl_writeEnable, t_ctrl_writeReg[4:0], t_ctrl_readRegA[4:0],
//          t_ctrl_readRegB[4:0], t_data_writeReg[31:0],
//          t_data_readRegA[31:0], t_data_readRegB[31:0]
interface regfile_bist_if;
   logic        t_ctrl_writeEnable;
   logic [4:0]  t_ctrl_writeReg;
   logic [4:0]  t_ctrl_readRegA;
   logic [4:0]  t_ctrl_readRegB;
   logic [31:0] t_data_writeReg;
   logic [31:0] t_data_readRegA;
   logic [31:0] t_data_readRegB;

   modport master (
      output t_ctrl_writeEnable, t_ctrl_writeReg, t_ctrl_readRegA,
             t_ctrl_readRegB, t_data_writeReg,
      input  t_data_readRegA, t_data_readRegB
   );
   modport slave (
      input  t_ctrl_writeEnable, t_ctrl_writeReg, t_ctrl_readRegA,
             t_ctrl_readRegB, t_data_writeReg,
      output t_data_readRegA, t_data_readRegB
   );
endinterface

// File: rtl/regfile_bist.sv
// Built-in self-test initiator for the register file test port.
// Writes a seed-derived pattern (then its inverse) into every register, reads
// all registers back on both ports and reports pass or the first mismatch.
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   start               : one-cycle pulse, begins a run (ignored while busy)
//   test, busy          : high while a run is in progress (test = mux select)
//   done, pass          : sticky completion flag, 1 = no mismatch
//   fail_reg, fail_data : register index / read data of the first mismatch
//   rf                  : regfile test port (master side)
// Parameters: SEED (base pattern), READ_WAIT (0..3 read settle cycles).
// Optional macro REGFILE_BIST_R0_WRITE_EN: also write r0 (expected to read 0).
module regfile_bist #(
   parameter logic [31:0] SEED      = 32'hA5A5_5A5A,
   parameter int unsigned READ_WAIT = 1
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           start,
   output logic           test,
   output logic           busy,
   output logic           done,
   output logic           pass,
   output logic [4:0]     fail_reg,
   output logic [31:0]    fail_data,
   regfile_bist_if.master rf
);
   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_READ, S_WAIT, S_CHECK, S_DONE
   } state_e;

`ifdef REGFILE_BIST_R0_WRITE_EN
   localparam logic [4:0] FIRST_WR = 5'd0;
`else
   localparam logic [4:0] FIRST_WR = 5'd1;
`endif
   localparam logic [1:0] WAIT_LAST = (READ_WAIT == 0) ? 2'd0 : 2'(READ_WAIT - 1);

   function automatic logic [31:0] pat(input logic [4:0] r, input logic ph);
      logic [31:0] p;
      p = SEED ^ {r, r, r, r, r, r, r[1:0]};
      return ph ? ~p : p;
   endfunction

   // r0 always reads as zero, whatever was written to it
   function automatic logic [31:0] expv(input logic [4:0] r, input logic ph);
      return (r == 5'd0) ? 32'd0 : pat(r, ph);
   endfunction

   state_e      state_q, state_d;
   logic        phase_q, phase_d;
   logic [4:0]  idx_q, idx_d;
   logic [1:0]  wcnt_q, wcnt_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic [4:0]  freg_q, freg_d;
   logic [31:0] fdata_q, fdata_d;

   logic [4:0]  idx_b;
   logic        miss_a, miss_b;

   assign idx_b  = 5'd31 - idx_q;
   assign miss_a = rf.t_data_readRegA != expv(idx_q, phase_q);
   assign miss_b = rf.t_data_readRegB != expv(idx_b, phase_q);

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      idx_d   = idx_q;
      wcnt_d  = wcnt_q;
      done_d  = done_q;
      pass_d  = pass_q;
      freg_d  = freg_q;
      fdata_d = fdata_q;
      test                  = 1'b0;
      rf.t_ctrl_writeEnable = 1'b0;
      rf.t_ctrl_writeReg    = 5'd0;
      rf.t_data_writeReg    = 32'd0;
      rf.t_ctrl_readRegA    = 5'd0;
      rf.t_ctrl_readRegB    = 5'd0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_WRITE;
               phase_d = 1'b0;
               idx_d   = FIRST_WR;
            end
         end
         S_WRITE: begin
            test                  = 1'b1;
            rf.t_ctrl_writeEnable = 1'b1;
            rf.t_ctrl_writeReg    = idx_q;
            rf.t_data_writeReg    = pat(idx_q, phase_q);
            if (idx_q == 5'd31) begin
               state_d = S_READ;
               idx_d   = 5'd0;
            end else begin
               idx_d = idx_q + 5'd1;
            end
         end
         S_READ: begin
            test               = 1'b1;
            rf.t_ctrl_readRegA = idx_q;
            rf.t_ctrl_readRegB = idx_b;
            wcnt_d             = 2'd0;
            state_d            = (READ_WAIT == 0) ? S_CHECK : S_WAIT;
         end
         S_WAIT: begin
            test               = 1'b1;
            rf.t_ctrl_readRegA = idx_q;
            rf.t_ctrl_readRegB = idx_b;
            wcnt_d             = wcnt_q + 2'd1;
            if (wcnt_q == WAIT_LAST) state_d = S_CHECK;
         end
         S_CHECK: begin
            test               = 1'b1;
            rf.t_ctrl_readRegA = idx_q;
            rf.t_ctrl_readRegB = idx_b;
            if (miss_a || miss_b) begin
               // port A wins when both ports mismatch
               state_d = S_DONE;
               pass_d  = 1'b0;
               freg_d  = miss_a ? idx_q : idx_b;
               fdata_d = miss_a ? rf.t_data_readRegA : rf.t_data_readRegB;
            end else if (idx_q != 5'd31) begin
               idx_d   = idx_q + 5'd1;
               state_d = S_READ;
            end else if (!phase_q) begin
               phase_d = 1'b1;
               idx_d   = FIRST_WR;
               state_d = S_WRITE;
            end else begin
               state_d = S_DONE;
               pass_d  = 1'b1;
               freg_d  = 5'd0;
               fdata_d = 32'd0;
            end
         end
         S_DONE: begin
            // done follows one edge after entering DONE
            done_d = 1'b1;
            if (start) begin
               state_d = S_WRITE;
               phase_d = 1'b0;
               idx_d   = FIRST_WR;
               done_d  = 1'b0;
               pass_d  = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         phase_q <= 1'b0;
         idx_q   <= 5'd0;
         wcnt_q  <= 2'd0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         freg_q  <= 5'd0;
         fdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         idx_q   <= idx_d;
         wcnt_q  <= wcnt_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         freg_q  <= freg_d;
         fdata_q <= fdata_d;
      end
   end

   assign busy      = test;
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_reg  = freg_q;
   assign fail_data = fdata_q;
endmodule

// File: tb/tb_regfile_bist.sv
module tb_regfile_bist;
   localparam logic [31:0] SEED = 32'hA5A5_5A5A;
   localparam int RW  = 1;
   localparam int PER = RW + 2;
`ifdef REGFILE_BIST_R0_WRITE_EN
   localparam int W   = 32;
   localparam bit R0W = 1'b1;
`else
   localparam int W   = 31;
   localparam bit R0W = 1'b0;
`endif
   localparam int PASS_LAT = 2 * (W + 32 * PER) + 1;

   logic        clock = 1'b0;
   logic        reset, start;
   logic        test, busy, done, pass;
   logic [4:0]  fail_reg;
   logic [31:0] fail_data;

   regfile_bist_if rf();

   regfile_bist #(.SEED(SEED), .READ_WAIT(RW)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .test      (test),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .fail_reg  (fail_reg),
      .fail_data (fail_data),
      .rf        (rf.master)
   );

   always #5 clock = ~clock;

   // register file model; mode: 0 healthy, 1 r7 bit3 stuck-at-1,
   // 2 r0 writable, 3 port B decode returns r30 for r31
   logic [31:0] regs [32];
   int          mode;
   logic [4:0]  bsel;

   always @(posedge clock)
      if (rf.t_ctrl_writeEnable && (rf.t_ctrl_writeReg != 5'd0 || mode == 2))
         regs[rf.t_ctrl_writeReg] <= rf.t_data_writeReg;

   always_comb begin
      rf.t_data_readRegA = (rf.t_ctrl_readRegA == 5'd0 && mode != 2) ? 32'd0 : regs[rf.t_ctrl_readRegA];
      if (mode == 1 && rf.t_ctrl_readRegA == 5'd7) rf.t_data_readRegA = rf.t_data_readRegA | 32'h8;
      bsel = (mode == 3 && rf.t_ctrl_readRegB == 5'd31) ? 5'd30 : rf.t_ctrl_readRegB;
      rf.t_data_readRegB = (bsel == 5'd0 && mode != 2) ? 32'd0 : regs[bsel];
      if (mode == 1 && bsel == 5'd7) rf.t_data_readRegB = rf.t_data_readRegB | 32'h8;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pat(input logic [4:0] r, input logic ph);
      logic [31:0] p;
      p = SEED ^ {r, r, r, r, r, r, r[1:0]};
      return ph ? ~p : p;
   endfunction

   typedef struct {
      logic        pass;
      logic [4:0]  freg;
      logic [31:0] fdata;
      int          lat;
   } exp_t;

   exp_t sb[$];

   function automatic exp_t mk(input logic p, input logic [4:0] r, input logic [31:0] d, input int l);
      exp_t e;
      e.pass = p; e.freg = r; e.fdata = d; e.lat = l;
      return e;
   endfunction

   function automatic logic [127:0] all_outs();
      return {test, busy, done, pass, fail_reg, fail_data, rf.t_ctrl_writeEnable,
              rf.t_ctrl_writeReg, rf.t_ctrl_readRegA, rf.t_ctrl_readRegB, rf.t_data_writeReg};
   endfunction

   // one run: start pulse, optional extra start at edge restart_at, wait for done
   task automatic run(input int m, input exp_t e, input int restart_at);
      int   n, tcyc, bbad;
      bit   seen;
      exp_t x;
      mode = m;
      sb.push_back(e);
      start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
      chk("done_clr", done, 1'b0);
      n = 0; seen = 1'b0; bbad = 0;
      tcyc = test ? 1 : 0;
      while (n < 3000) begin
         if (n == restart_at) start = 1'b1;
         @(posedge clock); n++; #1 start = 1'b0;
         if (done) begin seen = 1'b1; break; end
         if (test) tcyc++;
         if (busy !== test) bbad++;
      end
      x = sb.pop_front();
      if (!seen) chk("timeout", 0, 1);
      else begin
         chk("latency", n, x.lat);
         chk("pass", pass, x.pass);
         chk("fail_reg", fail_reg, x.freg);
         chk("fail_data", fail_data, x.fdata);
         chk("test_cycles", tcyc, x.lat - 1);
         chk("busy_eq_test", bbad, 0);
         chk("done_bus_idle", {test, rf.t_ctrl_writeEnable, rf.t_ctrl_readRegA, rf.t_ctrl_readRegB}, 0);
      end
   endtask

   initial begin
      logic [31:0] p7;
      for (int i = 0; i < 32; i++) regs[i] = 32'd0;
      mode = 0; start = 1'b0; reset = 1'b1;
      repeat (2) @(posedge clock);
      #1 chk("reset_outs", all_outs(), 0);
      reset = 1'b0;

      run(0, mk(1'b1, 5'd0, 32'd0, PASS_LAT), -1);
      // start while busy is ignored; this run also starts from DONE
      run(0, mk(1'b1, 5'd0, 32'd0, PASS_LAT), 10);

      p7 = pat(5'd7, 1'b0);
      if (!p7[3]) run(1, mk(1'b0, 5'd7, p7 | 32'h8, W + 8 * PER + 1), -1);
      else        run(1, mk(1'b0, 5'd7, ~p7 | 32'h8, W + 32 * PER + W + 8 * PER + 1), -1);

      run(3, mk(1'b0, 5'd31, pat(5'd30, 1'b0), W + PER + 1), -1);

      if (R0W) run(2, mk(1'b0, 5'd0, SEED, W + PER + 1), -1);
      else     run(2, mk(1'b1, 5'd0, 32'd0, PASS_LAT), -1);

      // reset 40 cycles into a run aborts it
      mode = 0;
      start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
      repeat (39) @(posedge clock);
      #1 chk("mid_run_busy", test, 1'b1);
      reset = 1'b1;
      @(posedge clock); #1 reset = 1'b0;
      chk("abort_outs", all_outs(), 0);
      @(posedge clock); #1 chk("abort_idle", {test, done}, 0);

      run(0, mk(1'b1, 5'd0, 32'd0, PASS_LAT), -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
